// File: rtl/mult_final_cpa_if.sv
// Operand/result handshake bundle for the serial final carry-propagate adder.
// Upstream side: in_valid/in_ready with sum_vec/carry_vec. Downstream side: out_valid/out_ready with result/cout.
interface mult_final_cpa_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, result, cout
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, result, cout
    );
endinterface

// File: rtl/mult_final_cpa.sv
// Serial carry-propagate adder for the multiplier's redundant sum/carry pair, CHUNK_W bits per cycle.
// Optional MULT_FINAL_CPA_EARLY_EXIT_EN: finish early once all remaining operand chunks are zero.
module mult_final_cpa #(
    parameter int WIDTH   = 64,
    parameter int CHUNK_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    mult_final_cpa_if.slave bus
);
    localparam int N  = WIDTH / CHUNK_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH % CHUNK_W != 0) begin : g_width_check
            $error("mult_final_cpa: WIDTH must be a multiple of CHUNK_W");
        end
    endgenerate

    logic [1:0]         state;
    logic [KW-1:0]      k;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;

    logic [CHUNK_W:0]   csum;
    logic               last;
    logic               early;
    logic               accept;
    logic [WIDTH-1:0]   res_next;

    assign bus.in_ready  = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Operands shift right each cycle, so the active chunk is always the low one.
    assign csum = {1'b0, a_q[CHUNK_W-1:0]} + {1'b0, b_q[CHUNK_W-1:0]} + {{CHUNK_W{1'b0}}, carry_q};
    assign last = (k == KW'(N - 1));

`ifdef MULT_FINAL_CPA_EARLY_EXIT_EN
    logic             rest_zero;
    logic [WIDTH-1:0] keep_mask;
    assign rest_zero = (((a_q | b_q) >> CHUNK_W) == '0);
    assign early     = !last && rest_zero;
    assign keep_mask = {WIDTH{1'b1}} >> ((N - 1 - int'(k)) * CHUNK_W);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        res_next = result_q;
        res_next[int'(k)*CHUNK_W +: CHUNK_W] = csum[CHUNK_W-1:0];
`ifdef MULT_FINAL_CPA_EARLY_EXIT_EN
        // Upper chunks reduce to the pending carry in the next chunk and zeros above it.
        if (early)
            res_next = (res_next & keep_mask)
                     | (WIDTH'(csum[CHUNK_W]) << ((int'(k) + 1) * CHUNK_W));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.sum_vec;
                        b_q     <= bus.carry_vec;
                        carry_q <= 1'b0;
                        k       <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    result_q <= res_next;
                    a_q      <= a_q >> CHUNK_W;
                    b_q      <= b_q >> CHUNK_W;
                    carry_q  <= csum[CHUNK_W];
                    k        <= k + KW'(1);
                    if (last) begin
                        cout_q <= csum[CHUNK_W];
                        state  <= DONE;
                    end else if (early) begin
                        cout_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            a_q     <= bus.sum_vec;
                            b_q     <= bus.carry_vec;
                            carry_q <= 1'b0;
                            k       <= '0;
                            state   <= ADD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_final_cpa.sv
// Directed bench for mult_final_cpa at WIDTH=64, CHUNK_W=16, with a short randomized tail.
module tb_mult_final_cpa;
    localparam int WIDTH = 64;

`ifdef MULT_FINAL_CPA_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mult_final_cpa_if #(.WIDTH(WIDTH)) bus ();

    mult_final_cpa #(.WIDTH(WIDTH), .CHUNK_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until the acceptance edge has passed.
    task automatic send(input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.sum_vec   = a;
        bus.carry_vec = b;
        while (!bus.in_ready && n < 50) begin
            tick;
            n++;
        end
        chk("accept_ready", 65'(bus.in_ready), 65'd1);
        tick;
        bus.in_valid  = 1'b0;
        bus.sum_vec   = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.carry_vec = 64'hFEED_FACE_FEED_FACE;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick;
            lat++;
        end
        chk("out_timeout", 65'(bus.out_valid), 65'd1);
    endtask

    task automatic retire;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("retired", 65'(bus.out_valid), 65'd0);
    endtask

    initial begin
        int lat;
        logic [63:0] a, b, hold_res;
        logic        hold_cout;
        logic [64:0] ref_sum;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_vec   = '0;
        bus.carry_vec = '0;
        tick;
        chk("rst_in_ready", 65'(bus.in_ready), 65'd0);
        chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
        chk("rst_result", 65'(bus.result), 65'd0);
        chk("rst_cout", 65'(bus.cout), 65'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 65'(bus.in_ready), 65'd1);

        // Full ripple through every chunk.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        wait_out(lat);
        chk("ripple_lat", 65'(lat), 65'd4);
        chk("ripple_res", 65'(bus.result), 65'd0);
        chk("ripple_cout", 65'(bus.cout), 65'd1);
        retire;

        // in_valid during ADD is ignored and must not disturb the sum.
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
        bus.in_valid  = 1'b1;
        bus.sum_vec   = 64'h5555_5555_5555_5555;
        bus.carry_vec = 64'hAAAA_AAAA_AAAA_AAAA;
        chk("busy_in_ready", 65'(bus.in_ready), 65'd0);
        wait_out(lat);
        bus.in_valid = 1'b0;
        chk("mixed_lat", 65'(lat), 65'd4);
        chk("mixed_res", 65'(bus.result), 65'h0_1234_5678_9ABC_DF00);
        chk("mixed_cout", 65'(bus.cout), 65'd0);
        retire;

        // Backpressure with a new pair waiting, then accept from DONE.
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        wait_out(lat);
        bus.in_valid  = 1'b1;
        bus.sum_vec   = 64'h1234_0000_FFFF_FFFF;
        bus.carry_vec = 64'h0000_0001_0000_0001;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 65'(bus.out_valid), 65'd1);
            chk("bp_in_ready", 65'(bus.in_ready), 65'd0);
            chk("bp_res", {bus.cout, bus.result}, 65'h1_0000_0000_0000_0000);
            tick;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("done_in_ready", 65'(bus.in_ready), 65'd1);
        tick;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("b2b_valid_drop", 65'(bus.out_valid), 65'd0);
        wait_out(lat);
        chk("b2b_lat", 65'(lat), 65'd4);
        chk("b2b_res", {bus.cout, bus.result}, 65'h0_1234_0002_0000_0000);
        retire;

        // Reset during the second ADD cycle discards the result.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_valid", 65'(bus.out_valid), 65'd0);
        chk("mid_rst_res", {bus.cout, bus.result}, 65'd0);
        #1;
        chk("mid_rst_in_ready", 65'(bus.in_ready), 65'd1);
        for (int i = 0; i < 6; i++) tick;
        chk("mid_rst_no_stale", 65'(bus.out_valid), 65'd0);
        send(64'hFFFF, 64'h1);
        wait_out(lat);
        chk("small_lat", 65'(lat), 65'(LAT_SMALL));
        chk("small_res", {bus.cout, bus.result}, 65'h0_0000_0000_0001_0000);
        retire;

        // Boundary operands.
        send(64'h0, 64'h0);
        wait_out(lat);
        chk("zero_res", {bus.cout, bus.result}, 65'd0);
        retire;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_out(lat);
        chk("max_res", {bus.cout, bus.result}, 65'h1_FFFF_FFFF_FFFF_FFFE);
        retire;

        // Randomized operands with random output stalls.
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = a >> (16 * $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) b = b >> (16 * $urandom_range(1, 3));
            ref_sum = {1'b0, a} + {1'b0, b};
            for (int j = 0, n = int'($urandom_range(0, 2)); j < n; j++) tick;
            send(a, b);
            wait_out(lat);
            hold_res  = bus.result;
            hold_cout = bus.cout;
            for (int j = 0, n = int'($urandom_range(0, 3)); j < n; j++) tick;
            chk("rand_hold", {bus.cout, bus.result}, {hold_cout, hold_res});
            chk("rand_res", {bus.cout, bus.result}, ref_sum);
            retire;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
